// File: rtl/spi_regfile_rw.sv
// SPI mode-0 peripheral register file with read-back, oversampled in the clk domain.
// A frame is {rw, addr, data}, sent MSB first (rw = 1 means write). Writes land at commit,
// after chip select is released. Bad frames raise an error strobe instead of writing.
module spi_regfile_rw #(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       addr_err,
    output logic                       frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);

    typedef enum logic [1:0] {StIdle, StCmd, StData, StCommit} state_t;

    // Synchronisers and edge detectors
    logic [SYNC_N-1:0] sclk_sync, copi_sync, ncs_sync;
    logic              sclk_dly, ncs_dly;
    logic              sclk_s, copi_s, ncs_s;
    logic              sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    // Frame state
    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]          in_shift_q, in_shift_d;
    logic [DATA_W-1:0]           out_shift_q, out_shift_d;
    logic                        cipo_q, cipo_d;
    logic                        rd_q, rd_d;
    logic [NUM_REGS*DATA_W-1:0]  regs_q, regs_d;
    logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;
    logic                        wr_strobe_q, wr_strobe_d;
    logic                        addr_err_q, addr_err_d;
    logic                        frame_err_q, frame_err_d;

    // Decoded fields
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_read;
    logic              frm_rw;
    logic [ADDR_W-1:0] frm_addr;
    logic [DATA_W-1:0] frm_data;
    logic [DATA_W-1:0] rd_data;

    assign sclk_s = sclk_sync[SYNC_N-1];
    assign copi_s = copi_sync[SYNC_N-1];
    assign ncs_s  = ncs_sync[SYNC_N-1];

    assign sclk_rise = sclk_s & ~sclk_dly;
    assign sclk_fall = ~sclk_s & sclk_dly;
    assign ncs_rise  = ncs_s & ~ncs_dly;
    assign ncs_fall  = ~ncs_s & ncs_dly;

    // While still in CMD the low 1+ADDR_W bits of the shifter hold {rw, addr}
    assign cmd_addr = in_shift_q[ADDR_W-1:0];
    assign cmd_read = ~in_shift_q[ADDR_W];

    // At commit a full frame occupies the whole shifter
    assign frm_rw   = in_shift_q[FRAME_W-1];
    assign frm_addr = in_shift_q[FRAME_W-2 -: ADDR_W];
    assign frm_data = in_shift_q[DATA_W-1:0];

    // Sync flops reset to 0 so a reset taken with ncs low cannot fake an ncs_fall
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '0;
            sclk_dly  <= 1'b0;
            ncs_dly   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_N-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_N-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_N-2:0], ncs};
            sclk_dly  <= sclk_s;
            ncs_dly   <= ncs_s;
        end
    end

    // Read-back mux; out-of-range addresses return zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(cmd_addr) == i) begin
                rd_data = regs_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic for the frame FSM, shifters and commit decisions
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        in_shift_d  = in_shift_q;
        out_shift_d = out_shift_q;
        cipo_d      = cipo_q;
        rd_d        = rd_q;
        regs_d      = regs_q;
        wr_addr_d   = wr_addr_q;
        wr_strobe_d = 1'b0;
        addr_err_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                bit_cnt_d   = '0;
                in_shift_d  = '0;
                out_shift_d = '0;
                cipo_d      = 1'b0;
                rd_d        = 1'b0;
                if (ncs_fall) begin
                    state_d = StCmd;
                end
            end

            StCmd: begin
                if (ncs_rise) begin
                    state_d = StCommit;
                end else if (bit_cnt_q == CNT_CMD) begin
                    state_d = StData;
                    rd_d    = cmd_read;
                    if (cmd_read) begin
                        out_shift_d = rd_data;
                        cipo_d      = rd_data[DATA_W-1];
                    end
                end else if (sclk_rise) begin
                    in_shift_d = {in_shift_q[FRAME_W-2:0], copi_s};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                end
            end

            StData: begin
                if (ncs_rise) begin
                    state_d = StCommit;
                end else begin
                    if (sclk_rise) begin
                        in_shift_d = {in_shift_q[FRAME_W-2:0], copi_s};
                        if (bit_cnt_q != CNT_MAX) begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    // The fall right after the last address bit must keep the MSB on cipo
                    // for the first data rising edge, so shifting starts one fall later.
                    if (sclk_fall && rd_q && (bit_cnt_q > CNT_CMD)) begin
                        out_shift_d = {out_shift_q[DATA_W-2:0], 1'b0};
                        cipo_d      = out_shift_q[DATA_W-2];
                    end
                end
            end

            StCommit: begin
                state_d     = ncs_fall ? StCmd : StIdle;
                bit_cnt_d   = '0;
                in_shift_d  = '0;
                out_shift_d = '0;
                cipo_d      = 1'b0;
                rd_d        = 1'b0;
                if (bit_cnt_q != CNT_FRAME) begin
                    frame_err_d = 1'b1;
                end else if (int'(frm_addr) >= NUM_REGS) begin
                    addr_err_d = 1'b1;
                end else if (frm_rw) begin
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = frm_addr;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (int'(frm_addr) == i) begin
                            regs_d[i*DATA_W +: DATA_W] = frm_data;
                        end
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            in_shift_q  <= '0;
            out_shift_q <= '0;
            cipo_q      <= 1'b0;
            rd_q        <= 1'b0;
            regs_q      <= '0;
            wr_addr_q   <= '0;
            wr_strobe_q <= 1'b0;
            addr_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            in_shift_q  <= in_shift_d;
            out_shift_q <= out_shift_d;
            cipo_q      <= cipo_d;
            rd_q        <= rd_d;
            regs_q      <= regs_d;
            wr_addr_q   <= wr_addr_d;
            wr_strobe_q <= wr_strobe_d;
            addr_err_q  <= addr_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Pad enable falls as soon as the ncs_rise pulse is seen
    assign cipo_oe   = (state_q == StData) & rd_q & ~ncs_rise;
    assign cipo      = cipo_q & cipo_oe;
    assign regs_flat = regs_q;
    assign wr_addr   = wr_addr_q;
    assign wr_strobe = wr_strobe_q;
    assign addr_err  = addr_err_q;
    assign frame_err = frame_err_q;

endmodule
